// File: rtl/rotr_seq.sv
`default_nettype none
// ============================================================================
// Module      : rotr_seq
// Description : Multi-cycle right rotator with valid/ready handshakes on both
//               sides. Rotates the latched word right one bit per clock
//               (two bits per clock when ROT_FAST_EN is defined) and holds
//               the result until the consumer accepts it.
// Options     : ROT_FAST_EN - rotate by two while at least two steps remain.
// Revision    : 1.0 - initial release
// ============================================================================
module rotr_seq #(
  parameter int WIDTH = 4,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_amt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ROT  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [SHW-1:0] c_one = SHW'(1);
`ifdef ROT_FAST_EN
  // Kept one bit wider than the count so "2" stays representable at WIDTH=2.
  localparam logic [SHW:0]   c_two = (SHW + 1)'(2);
`endif

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] w_data_nxt;
  logic [SHW-1:0]   r_count;
  logic [SHW-1:0]   w_count_nxt;
  logic [WIDTH-1:0] r_out;
  logic [WIDTH-1:0] w_out_nxt;
  logic [WIDTH-1:0] w_step_data;
  logic [SHW-1:0]   w_step_count;

  // Single rotation step taken in ROT; the wide step is only used while at
  // least two single-bit steps remain, so the result is identical either way.
  always_comb begin
    w_step_data  = {r_data[0], r_data[WIDTH-1:1]};
    w_step_count = r_count - c_one;
`ifdef ROT_FAST_EN
    if ({1'b0, r_count} >= c_two) begin
      w_step_data  = (r_data >> 2) | (r_data << (WIDTH - 2));
      w_step_count = r_count - c_two[SHW-1:0];
    end
`endif
  end

  // Next-state and datapath selection; the output word only changes on the
  // transition into DONE so it stays stable through IDLE and the next ROT.
  always_comb begin
    w_state_nxt = r_state;
    w_data_nxt  = r_data;
    w_count_nxt = r_count;
    w_out_nxt   = r_out;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_data_nxt  = in_data;
          w_count_nxt = in_amt;
          if (in_amt == '0) begin
            w_state_nxt = DONE;
            w_out_nxt   = in_data;
          end else begin
            w_state_nxt = ROT;
          end
        end
      end
      ROT: begin
        w_data_nxt  = w_step_data;
        w_count_nxt = w_step_count;
        if (w_step_count == '0) begin
          w_state_nxt = DONE;
          w_out_nxt   = w_step_data;
        end
      end
      DONE: begin
        if (out_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_data  <= '0;
      r_count <= '0;
      r_out   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_data  <= w_data_nxt;
      r_count <= w_count_nxt;
      r_out   <= w_out_nxt;
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state != IDLE);
  assign out_data  = r_out;

endmodule
`default_nettype wire

// File: tb/tb_rotr_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_rotr_seq
// Description : Directed, table-driven bench for rotr_seq (WIDTH=4), with
//               hand-written sequences for back-pressure, blocked requests,
//               round-trip through a left-rotate model and mid-op reset.
// Options     : ROT_FAST_EN - must match the define used for the design.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rotr_seq;

  localparam int WIDTH = 4;
  localparam int SHW   = 2;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [SHW-1:0]   in_amt;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             busy;

  int n_chk  = 0;
  int n_fail = 0;

  rotr_seq #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_amt   (in_amt),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] data;
    logic [1:0] amt;
    logic [3:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] rotl4(input logic [3:0] w, input logic [1:0] a);
    logic [7:0] dbl;
    dbl = {w, w} << a;
    return dbl[7:4];
  endfunction

  function automatic int exp_lat(input logic [1:0] a);
`ifdef ROT_FAST_EN
    return (int'(a) + 1) / 2;
`else
    return int'(a);
`endif
  endfunction

  // Starts at a negedge in IDLE; ends at a negedge back in IDLE.
  task automatic run_op(input string name, input logic [3:0] d, input logic [1:0] a,
                        input logic [3:0] exp);
    int lat;
    check({name, ".in_ready"}, 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    in_data   = d;
    in_amt    = a;
    out_ready = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    forever begin
      @(negedge clk);
      if (out_valid || lat >= 20) break;
      @(posedge clk);
      lat++;
    end
    check({name, ".latency"}, 32'(lat), 32'(exp_lat(a)));
    check({name, ".data"}, 32'(out_data), 32'(exp));
    check({name, ".ready_in_done"}, 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check({name, ".idle_after"}, {30'd0, out_valid, in_ready}, 32'b01);
    check({name, ".held"}, 32'(out_data), 32'(exp));
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{4'b0001, 2'd1, 4'b1000};
    vecs[1] = '{4'b1011, 2'd3, 4'b0111};
    vecs[2] = '{4'b1010, 2'd0, 4'b1010};
    vecs[3] = '{4'b1100, 2'd2, 4'b0011};
    vecs[4] = '{4'b0110, 2'd1, 4'b0011};
    vecs[5] = '{4'b1000, 2'd3, 4'b0001};
    vecs[6] = '{4'b1111, 2'd2, 4'b1111};
    vecs[7] = '{4'b0101, 2'd1, 4'b1010};

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_amt = '0; out_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.out_data", 32'(out_data), 32'd0);
    check("rst.busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst.in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle.outs", {26'd0, out_valid, busy, in_ready, out_data[2:0]}, {26'd0, 6'b001000});
      check("idle.data", 32'(out_data), 32'd0);
    end

    // Table-driven vectors
    for (int i = 0; i < 8; i++)
      run_op($sformatf("vec%0d", i), vecs[i].data, vecs[i].amt, vecs[i].exp);

    // Back-pressure: result held with out_ready low
    in_valid = 1'b1; in_data = 4'b1011; in_amt = 2'd3; out_ready = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (exp_lat(2'd3)) @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("hold.valid", 32'(out_valid), 32'd1);
      check("hold.data", 32'(out_data), 32'b0111);
      check("hold.in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check("hold.release", {29'd0, out_valid, in_ready, busy}, 32'b010);
    check("hold.kept", 32'(out_data), 32'b0111);

    // amt=0 then a request presented during DONE must wait for the handshake
    in_valid = 1'b1; in_data = 4'b1010; in_amt = 2'd0;
    @(posedge clk);
    #1 in_data = 4'b0011; in_amt = 2'd1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("blk.valid", 32'(out_valid), 32'd1);
      check("blk.data", 32'(out_data), 32'b1010);
      check("blk.in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check("blk.idle", {29'd0, out_valid, in_ready, busy}, 32'b010);
    check("blk.kept", 32'(out_data), 32'b1010);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("blk.accepted", 32'(busy), 32'd1);
    repeat (exp_lat(2'd1)) @(posedge clk);
    @(negedge clk);
    check("blk.second.valid", 32'(out_valid), 32'd1);
    check("blk.second.data", 32'(out_data), 32'b1001);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);

    // Round trip through the left-rotate model
    for (int w = 0; w < 16; w++)
      for (int a = 0; a < 4; a++)
        run_op($sformatf("rt_w%0d_a%0d", w, a), rotl4(4'(w), 2'(a)), 2'(a), 4'(w));

    // Reset mid-ROT
    in_valid = 1'b1; in_data = 4'b1100; in_amt = 2'd3;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("mid.busy", 32'(busy), 32'd1);
    check("mid.valid", 32'(out_valid), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("mid.rst", {29'd0, out_valid, busy, in_ready}, 32'b001);
    check("mid.rst.data", 32'(out_data), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("mid.after", {26'd0, out_valid, busy, in_ready, 3'd0} | 32'(out_data), 32'b001000);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/rotr_seq.md
Name: rotr_seq

Overview:
- Multi-cycle right-rotator: the inverse of the team's combinational 4-bit left rotator (q = rotl(in, shift)).
- Accepts a word and a rotation amount over a valid/ready handshake, rotates right one bit per clock, and presents the result over a second valid/ready handshake.
- Feeding the left rotator's output and its shift value through this block reproduces the original word; the pair is used for round-trip checking and for serialized rotation where area matters more than latency.

Parameters:
- WIDTH, 4, data width in bits; must be a power of two, >= 2.
- SHW, $clog2(WIDTH), width of the amount field (derived; do not override).

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  in_data/in_amt valid
- in_ready  output  1  block can accept a new request
- in_data  input  WIDTH  word to rotate
- in_amt  input  SHW  right-rotate amount, 0..WIDTH-1
- out_valid  output  1  out_data holds a result
- out_ready  input  1  consumer accepts the result
- out_data  output  WIDTH  rotr(in_data, in_amt)
- busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (rst_n=0, asynchronous, any state): state=IDLE, data reg=0, count=0, out_valid=0, in_ready=1 (once rst_n=1), out_data=0, busy=0.
- Accept: in_valid && in_ready at edge E0. Latch data and count=in_amt.
  - in_amt=0: go to DONE.
  - Otherwise: go to ROT.
- in_ready = (state==IDLE), combinational from state only. No dependence on out_ready.
- States:
  - IDLE: waits for accept.
  - ROT: each edge does data = {data[0], data[WIDTH-1:1]} and count = count-1. The edge on which count goes 1->0 moves to DONE with the final rotated value.
  - DONE: out_valid=1, out_data=data reg. On out_valid && out_ready, go to IDLE.
- Latency: out_valid high after edge E0+in_amt. Examples: amt=0 → visible right after the accept edge; amt=3 → after the 3rd edge following accept.
- Result is held stable in DONE while out_ready=0, indefinitely. out_data is unchanged when returning to IDLE; it holds its last value until the next DONE.
- No overlap: a new request is accepted only from IDLE, so minimum issue interval is in_amt+2 cycles.
- in_valid with in_ready=0 is ignored; the source must hold its request per valid/ready rules.
- out_data is registered; no combinational path from in_* to out_*.
- Reset asserted mid-ROT or mid-DONE aborts the operation; no partial result is emitted.

Optional Feature:
- Macro: ROT_FAST_EN.
- Defined: in ROT, if count >= 2 rotate right by 2 and decrement count by 2; else rotate by 1 and decrement by 1. Latency becomes ceil(in_amt/2) edges after E0 (amt=0 unchanged). Result is identical to the undefined case.
- Undefined: one bit per cycle as specified above.

Test Plan (WIDTH=4):
- Reset: rst_n=0 → out_valid=0, out_data=4'b0000, busy=0, in_ready=1. Release, then no stimulus for 5 cycles → all outputs unchanged.
- in_data=4'b0001, in_amt=1 → out_data=4'b1000; out_valid high 1 edge after accept.
- in_data=4'b1011, in_amt=3 with out_ready=0 for 4 cycles → out_data=4'b0111 held stable with out_valid=1 and in_ready=0 throughout. Then out_ready=1 → IDLE next edge.
- in_amt=0, in_data=4'b1010 → out_data=4'b1010 right after the accept edge. A second in_valid presented during DONE is not accepted until after the out handshake.
- Round trip: for all 16 words x 4 amounts, apply the left rotator's output rotl(w,a) with in_amt=a → out_data == w. Repeat with ROT_FAST_EN defined; amt=3 latency must be 2.
- rst_n pulsed low mid-ROT (in_data=4'b1100, amt=3, after 1 edge) → immediate out_valid=0, out_data=0, in_ready=1 after release; no stale result emitted.
